// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl
// Drives the select line of the downstream 2:1 data mux (out = sel ? x : y).
// In manual mode a debounced push-button toggles sel once per clean press.
// In auto mode sel toggles every AUTO_PERIOD cycles.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   btn      raw asynchronous push-button, active high
//   mode     0 = manual toggle, 1 = auto alternate (synchronous to clk)
//   sel      registered mux select, 1 selects x, 0 selects y
//   sel_chg  one-cycle pulse in the cycle sel takes a new value
//   pressed  debounced button level
//
// Debounce FSM
//   state | meaning
//   IDLE  | button released and stable
//   PDEB  | btn_s high, counting toward press acceptance
//   HELD  | press accepted, button held
//   RDEB  | btn_s low, counting toward release acceptance

module mux_sel_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int AUTO_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic mode,
  output logic sel,
  output logic sel_chg,
  output logic pressed
);

  localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PDEB = 2'd1,
    HELD = 2'd2,
    RDEB = 2'd3
  } state_t;

  state_t        state;
  logic          s1;
  logic          btn_s;
  logic [DW-1:0] deb_cnt;
  logic [AW-1:0] auto_cnt;
  logic          mode_q;
  logic          press_evt;
  logic          auto_evt;

  assign press_evt = (state == PDEB) && btn_s && (deb_cnt == DEB_LAST);

  // mode_q marks that auto mode was already active on the previous edge.
  // The first edge with mode=1 only arms the counter at 0, so the first
  // toggle lands AUTO_PERIOD edges after auto mode is entered.
  assign auto_evt = mode && mode_q && (auto_cnt == AUTO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      btn_s    <= 1'b0;
      state    <= IDLE;
      deb_cnt  <= '0;
      auto_cnt <= '0;
      mode_q   <= 1'b0;
      sel      <= 1'b0;
      sel_chg  <= 1'b0;
      pressed  <= 1'b0;
    end else begin
      s1    <= btn;
      btn_s <= s1;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= PDEB;
            deb_cnt <= '0;
          end
        end
        PDEB: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            pressed <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state   <= RDEB;
            deb_cnt <= '0;
          end
        end
        RDEB: begin
          // a bounce back high returns to HELD without a second press event
          if (btn_s) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            pressed <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase

      mode_q <= mode;
      if (!mode || !mode_q || auto_evt) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end

      // the current mode decides which event source may toggle sel
      sel_chg <= 1'b0;
      if (mode ? auto_evt : press_evt) begin
        sel     <= ~sel;
        sel_chg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl
// Self-checking bench for mux_sel_ctrl: a fixed vector table, directed
// multi-cycle sequences, and a randomized run against a behavioural model.

module tb_mux_sel_ctrl;

  localparam int DEB = 4;
  localparam int AP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic mode = 1'b0;
  logic sel;
  logic sel_chg;
  logic pressed;

  int checks = 0;
  int errors = 0;

  mux_sel_ctrl #(.DEB_CYCLES(DEB), .AUTO_PERIOD(AP)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .mode    (mode),
    .sel     (sel),
    .sel_chg (sel_chg),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic btn;
    logic mode;
    logic sel;
    logic chg;
    logic pr;
  } vec_t;

  vec_t tv[$];

  // Behavioural model: the button is taken as a level that flips once
  // DEB+1 consecutive synchronised samples disagree with it; auto mode
  // toggles whenever the run of mode=1 edges reaches 1 + k*AP.
  bit bhist[$];
  bit m_held;
  int m_run;
  int m_age;
  bit m_sel;
  bit m_chg;

  task automatic model_edge(input bit r, input bit b, input bit m);
    bit bs;
    bit press;
    bit tog;
    if (r) begin
      bhist.delete();
      m_held = 0;
      m_run  = 0;
      m_age  = 0;
      m_sel  = 0;
      m_chg  = 0;
      return;
    end
    bs = (bhist.size() >= 2) ? bhist[bhist.size()-2] : 1'b0;
    bhist.push_back(b);
    if (bhist.size() > 2) void'(bhist.pop_front());

    press = 0;
    if (bs != m_held) m_run++;
    else              m_run = 0;
    if (m_run == DEB + 1) begin
      m_held = ~m_held;
      m_run  = 0;
      press  = m_held;
    end

    if (m) m_age++;
    else   m_age = 0;
    tog = m ? (m_age > 1 && ((m_age - 1) % AP) == 0) : press;
    m_chg = tog;
    if (tog) m_sel = ~m_sel;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // apply inputs for one edge, advance the model, compare 1 ns after the edge
  task automatic step(input bit r, input bit b, input bit m);
    rst  = r;
    btn  = b;
    mode = m;
    @(posedge clk);
    model_edge(r, b, m);
    #1;
    chk("mdl_sel", sel, m_sel);
    chk("mdl_sel_chg", sel_chg, m_chg);
    chk("mdl_pressed", pressed, m_held);
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
  endtask

  initial begin
    int chg_at[$];
    int ntog;
    bit hold_lvl;
    int hold_len;
    bit rmode;
    bit sel_frozen;

    // reset + idle, then a clean 10-cycle press and release
    for (int r = 0; r < 42; r++) begin
      vec_t v;
      if (r < 2) begin
        v = '{rst: 1, btn: 0, mode: 0, sel: 0, chg: 0, pr: 0};
      end else if (r < 22) begin
        v = '{rst: 0, btn: 0, mode: 0, sel: 0, chg: 0, pr: 0};
      end else begin
        int i;
        i = r - 22;
        v = '{rst: 0, btn: (i < 10), mode: 0, sel: (i >= 6), chg: (i == 6),
              pr: (i >= 6 && i < 16)};
      end
      tv.push_back(v);
    end

    #2;
    foreach (tv[k]) begin
      step(tv[k].rst, tv[k].btn, tv[k].mode);
      chk("tbl_sel", sel, tv[k].sel);
      chk("tbl_sel_chg", sel_chg, tv[k].chg);
      chk("tbl_pressed", pressed, tv[k].pr);
    end

    // 3-cycle glitch must be discarded
    ntog = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, (i < 3), 0);
      if (sel_chg) ntog++;
    end
    chk_int("glitch_toggles", ntog, 0);

    // 10-cycle press with a low bounce at cycle 3: one toggle, at edge 10
    chg_at.delete();
    for (int i = 0; i < 30; i++) begin
      step(0, (i < 10 && i != 3), 0);
      if (sel_chg) chg_at.push_back(i);
    end
    chk_int("bounce_toggles", chg_at.size(), 1);
    if (chg_at.size() > 0) chk_int("bounce_edge", chg_at[0], 10);

    // auto mode from edge 0, with a press in the middle that must not count
    do_reset();
    chg_at.delete();
    for (int i = 0; i < 30; i++) begin
      step(0, (i >= 10 && i < 20), 1);
      if (sel_chg) chg_at.push_back(i);
      if (i == 24) chk("auto_sel_e24", sel, 1'b1);
    end
    chk_int("auto_toggles", chg_at.size(), 3);
    if (chg_at.size() == 3) begin
      chk_int("auto_edge0", chg_at[0], 8);
      chk_int("auto_edge1", chg_at[1], 16);
      chk_int("auto_edge2", chg_at[2], 24);
    end

    // mode 1 -> 0 at edge 12, back to 1 at edge 20
    do_reset();
    chg_at.delete();
    sel_frozen = 0;
    for (int i = 0; i < 36; i++) begin
      step(0, 0, (i < 12 || i >= 20));
      if (sel_chg) chg_at.push_back(i);
      if (i == 8) sel_frozen = sel;
      if (i == 19) chk("mswitch_frozen", sel, 1'b1);
      if (i == 27) chk("mswitch_sel_e27", sel, sel_frozen);
    end
    chk_int("mswitch_toggles", chg_at.size(), 2);
    if (chg_at.size() == 2) begin
      chk_int("mswitch_edge0", chg_at[0], 8);
      chk_int("mswitch_edge1", chg_at[1], 28);
    end

    // reset at edges 4-5 of a held press; re-acceptance at edge 12
    do_reset();
    chg_at.delete();
    for (int i = 0; i < 16; i++) begin
      step((i == 4 || i == 5), 1, 0);
      if (sel_chg) chg_at.push_back(i);
      if (i == 11) chk("rstmid_sel_e11", sel, 1'b0);
    end
    chk_int("rstmid_toggles", chg_at.size(), 1);
    if (chg_at.size() > 0) chk_int("rstmid_edge", chg_at[0], 12);
    for (int i = 0; i < 10; i++) step(0, 0, 0);

    // randomized run against the model
    hold_lvl = 0;
    hold_len = 0;
    rmode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_len == 0) begin
        hold_lvl = ~hold_lvl;
        hold_len = $urandom_range(1, 12);
      end
      hold_len--;
      if ($urandom_range(0, 39) == 0) rmode = ~rmode;
      step(($urandom_range(0, 299) == 0), hold_lvl, rmode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
